// File: rtl/dcm_ctrl_pkg.sv
// Shared types and constants for the dcm programming controller.
// Used by dcm_prog_ctrl, its interface and the dcm_ctrl_arb arbiter.
package dcm_ctrl_pkg;
    localparam int PROG_W = 3;
    localparam logic [PROG_W-1:0] PROG_MIN = 3'd0;
    localparam logic [PROG_W-1:0] PROG_MAX = 3'd7;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        SETTLE
    } state_e;

    typedef enum logic {
        REQ_BTN,
        REQ_HOST
    } req_e;
endpackage

// File: rtl/dcm_prog_ctrl_if.sv
// Request/handshake bundle between the requesters and dcm_prog_ctrl.
// master = buttons/host/tick side, slave = the controller.
interface dcm_prog_ctrl_if;
    import dcm_ctrl_pkg::*;

    logic              btn_up;
    logic              btn_down;
    logic              host_req;
    logic [PROG_W-1:0] host_prog;
    logic              host_ack;
    logic              tick;
    logic              dcm_update;
    logic [PROG_W-1:0] dcm_prog;
    logic [PROG_W-1:0] cur_prog;
    logic              busy;

    modport master (
        output btn_up, btn_down, host_req, host_prog, tick,
        input  host_ack, dcm_update, dcm_prog, cur_prog, busy
    );

    modport slave (
        input  btn_up, btn_down, host_req, host_prog, tick,
        output host_ack, dcm_update, dcm_prog, cur_prog, busy
    );
endinterface

// File: rtl/dcm_ctrl_arb.sv
// Two-way alternating-priority arbiter: on a tie the requester that
// was not granted last wins. last_grant resets to REQ_BTN.
module dcm_ctrl_arb
    import dcm_ctrl_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic req_host,
    input  logic req_btn,
    output logic gnt_host,
    output logic gnt_btn,
    output req_e last_grant
);

    req_e last_grant_q;
    req_e last_grant_d;

    always_comb begin
        gnt_host = en & req_host
                 & (~req_btn | (last_grant_q == REQ_BTN));
        gnt_btn  = en & req_btn
                 & (~req_host | (last_grant_q == REQ_HOST));
        last_grant_d = last_grant_q;
        if (gnt_host) begin
            last_grant_d = REQ_HOST;
        end else if (gnt_btn) begin
            last_grant_d = REQ_BTN;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q <= REQ_BTN;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;

endmodule

// File: rtl/dcm_prog_ctrl.sv
// Programs the dcm divider from speed buttons and a host port, then settles.
// Define DCM_PROG_CTRL_WRAP_EN to wrap 7<->0 instead of saturating.
module dcm_prog_ctrl
    import dcm_ctrl_pkg::*;
#(
    parameter logic [PROG_W-1:0] RESET_PROG   = 3'd0,
    parameter int                SETTLE_TICKS = 2
) (
    input logic            clock,
    input logic            reset,
    dcm_prog_ctrl_if.slave bus
);

    localparam int CNT_W = (SETTLE_TICKS < 1) ? 1 : $clog2(SETTLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(SETTLE_TICKS);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_up_q, pend_up_d;
    logic              pend_dn_q, pend_dn_d;
    logic              dcm_update_q, dcm_update_d;
    logic              host_ack_q, host_ack_d;
    logic [PROG_W-1:0] dcm_prog_q, dcm_prog_d;
    logic [PROG_W-1:0] cur_prog_q, cur_prog_d;
    logic              busy_q, busy_d;

    logic              up_raw, dn_raw, cancel;
    logic              eff_up, eff_dn;
    logic              gnt_host, gnt_btn;
    logic              at_limit;
    logic [PROG_W-1:0] step_code;
    req_e              last_grant;

    // Incoming pulses join the pending flags so IDLE grants them the same edge.
    always_comb begin
        up_raw    = pend_up_q | (bus.btn_up & ~bus.btn_down);
        dn_raw    = pend_dn_q | (bus.btn_down & ~bus.btn_up);
        cancel    = up_raw & dn_raw;
        eff_up    = up_raw & ~cancel;
        eff_dn    = dn_raw & ~cancel;
        step_code = eff_up ? cur_prog_q + 3'd1 : cur_prog_q - 3'd1;
    end

`ifdef DCM_PROG_CTRL_WRAP_EN
    assign at_limit = 1'b0;
`else
    assign at_limit = eff_up ? (cur_prog_q == PROG_MAX)
                             : (cur_prog_q == PROG_MIN);
`endif

    dcm_ctrl_arb u_arb (
        .clock      (clock),
        .reset      (reset),
        .en         (state_q == IDLE),
        .req_host   (bus.host_req),
        .req_btn    (eff_up | eff_dn),
        .gnt_host   (gnt_host),
        .gnt_btn    (gnt_btn),
        .last_grant (last_grant)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_up_d    = eff_up;
        pend_dn_d    = eff_dn;
        dcm_update_d = 1'b0;
        host_ack_d   = 1'b0;
        dcm_prog_d   = dcm_prog_q;
        cur_prog_d   = cur_prog_q;
        unique case (state_q)
            INIT: begin
                dcm_update_d = 1'b1;
                dcm_prog_d   = RESET_PROG;
                cur_prog_d   = RESET_PROG;
                cnt_d        = '0;
                state_d      = SETTLE;
            end
            IDLE: begin
                if (gnt_host) begin
                    dcm_update_d = 1'b1;
                    host_ack_d   = 1'b1;
                    dcm_prog_d   = bus.host_prog;
                    cur_prog_d   = bus.host_prog;
                    state_d      = SETTLE;
                end else if (gnt_btn) begin
                    pend_up_d = 1'b0;
                    pend_dn_d = 1'b0;
                    // A step past a limit is dropped without touching the divider.
                    if (!at_limit) begin
                        dcm_update_d = 1'b1;
                        dcm_prog_d   = step_code;
                        cur_prog_d   = step_code;
                        state_d      = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_END) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (bus.tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = INIT;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            pend_up_q    <= 1'b0;
            pend_dn_q    <= 1'b0;
            dcm_update_q <= 1'b0;
            host_ack_q   <= 1'b0;
            dcm_prog_q   <= RESET_PROG;
            cur_prog_q   <= RESET_PROG;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_up_q    <= pend_up_d;
            pend_dn_q    <= pend_dn_d;
            dcm_update_q <= dcm_update_d;
            host_ack_q   <= host_ack_d;
            dcm_prog_q   <= dcm_prog_d;
            cur_prog_q   <= cur_prog_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.dcm_update = dcm_update_q;
    assign bus.host_ack   = host_ack_q;
    assign bus.dcm_prog   = dcm_prog_q;
    assign bus.cur_prog   = cur_prog_q;
    assign bus.busy       = busy_q;

endmodule
